// File: rtl/count.sv
// Free-running modulo counter 0..MAX_COUNT with a registered, mode-selectable output.
// Modes: 0 = terminal pulse, 1 = toggle on wrap, 2 = duty-cycle compare.
module count #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9,
  parameter int unsigned OUT_MODE  = 0,
  parameter int unsigned DUTY      = 5
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  // Parameter legality checks; any violation stops elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("count: WIDTH must be at least 1");
  end
  if ((WIDTH < 32) && (64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_max
    $error("count: MAX_COUNT does not fit in WIDTH bits");
  end
  if (64'(DUTY) > (64'(MAX_COUNT) + 64'd1)) begin : g_bad_duty
    $error("count: DUTY must not exceed MAX_COUNT+1");
  end
  if (OUT_MODE > 2) begin : g_bad_mode
    $error("count: OUT_MODE must be 0, 1 or 2");
  end

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] cnt;
  logic             r_out;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_wrap;
  logic             w_out_next;

  always_comb begin
    w_wrap     = (cnt == MaxCnt);
    // >= also recovers any out-of-range value straight back to zero.
    w_cnt_next = (cnt >= MaxCnt) ? '0 : cnt + WIDTH'(1);
    w_out_next = 1'b0;
    if (OUT_MODE == 0) begin
      w_out_next = (w_cnt_next == MaxCnt);
    end else if (OUT_MODE == 1) begin
      w_out_next = r_out ^ w_wrap;
    end else begin
      w_out_next = (32'(w_cnt_next) < DUTY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      r_out <= 1'b0;
    end else begin
      cnt   <= w_cnt_next;
      r_out <= w_out_next;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_count.sv
// Self-checking bench for count: several parameterisations share one clock and reset and are
// compared every cycle against an edge-count based reference model.
module tb_count;

  logic clk;
  logic rst;
  logic o_m0, o_m1, o_d3, o_d0, o_d10, o_w3, o_z0, o_z1;

  int checks   = 0;
  int failures = 0;
  int k        = 0;  // edges seen since the last reset release

  count u_m0 (.clk(clk), .rst(rst), .out(o_m0));
  count #(.WIDTH(4), .MAX_COUNT(3), .OUT_MODE(1), .DUTY(0)) u_m1 (.clk(clk), .rst(rst), .out(o_m1));
  count #(.WIDTH(4), .MAX_COUNT(9), .OUT_MODE(2), .DUTY(3)) u_d3 (.clk(clk), .rst(rst), .out(o_d3));
  count #(.WIDTH(4), .MAX_COUNT(9), .OUT_MODE(2), .DUTY(0)) u_d0 (.clk(clk), .rst(rst), .out(o_d0));
  count #(.WIDTH(4), .MAX_COUNT(9), .OUT_MODE(2), .DUTY(10)) u_d10 (
    .clk(clk), .rst(rst), .out(o_d10)
  );
  count #(.WIDTH(3), .MAX_COUNT(7), .OUT_MODE(0), .DUTY(0)) u_w3 (.clk(clk), .rst(rst), .out(o_w3));
  count #(.WIDTH(2), .MAX_COUNT(0), .OUT_MODE(0), .DUTY(0)) u_z0 (.clk(clk), .rst(rst), .out(o_z0));
  count #(.WIDTH(2), .MAX_COUNT(0), .OUT_MODE(1), .DUTY(0)) u_z1 (.clk(clk), .rst(rst), .out(o_z1));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic int exp_cnt(int m, int n);
    return n % (m + 1);
  endfunction

  function automatic logic exp_out(int mode, int m, int d, int n);
    if (n == 0) return 1'b0;
    case (mode)
      0:       return logic'(exp_cnt(m, n) == m);
      1:       return logic'((n / (m + 1)) % 2);
      default: return logic'(exp_cnt(m, n) < d);
    endcase
  endfunction

  task automatic chk_inst(input string tag, input int c, input logic o,
                          input int mode, input int m, input int d);
    int   ec;
    logic eo;
    ec = exp_cnt(m, k);
    eo = exp_out(mode, m, d, k);
    checks++;
    assert (c === ec) else begin
      failures++;
      $error("FAIL %s cnt got=%0d exp=%0d (k=%0d)", tag, c, ec, k);
    end
    checks++;
    assert (o === eo) else begin
      failures++;
      $error("FAIL %s out got=%b exp=%b (k=%0d)", tag, o, eo, k);
    end
  endtask

  task automatic check_all();
    chk_inst("m0",  int'(u_m0.cnt),  o_m0,  0, 9, 5);
    chk_inst("m1",  int'(u_m1.cnt),  o_m1,  1, 3, 0);
    chk_inst("d3",  int'(u_d3.cnt),  o_d3,  2, 9, 3);
    chk_inst("d0",  int'(u_d0.cnt),  o_d0,  2, 9, 0);
    chk_inst("d10", int'(u_d10.cnt), o_d10, 2, 9, 10);
    chk_inst("w3",  int'(u_w3.cnt),  o_w3,  0, 7, 0);
    chk_inst("z0",  int'(u_z0.cnt),  o_z0,  0, 0, 0);
    chk_inst("z1",  int'(u_z1.cnt),  o_z1,  1, 0, 0);
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) k++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    #12;
    check_all();            // reset state, after an edge at 10 ns held off by reset
    #3 rst = 1'b1;          // release at 15 ns; first counting edge at 20 ns
    repeat (22) step();

    // Asynchronous mid-cycle reset while the default counter sits at 6.
    while ((k % 10) != 6) step();
    #2 rst = 1'b0;
    k = 0;
    #1 check_all();
    repeat (2) step();      // edges under reset must change nothing
    #2 rst = 1'b1;
    repeat (12) step();

    // Randomised run lengths and reset pulses.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(45, 3);
      repeat (n) step();
      #($urandom_range(3, 1)) rst = 1'b0;
      k = 0;
      #1 check_all();
      n = $urandom_range(2, 0);
      repeat (n) step();
      @(negedge clk);
      #2 rst = 1'b1;
    end
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count.md
COUNT -- requirements
Module: count

Interface
REQ-001 Parameter WIDTH, default 4: counter register width in bits.
REQ-002 Parameter MAX_COUNT, default 9: terminal value; the counter runs 0..MAX_COUNT and wraps.
REQ-003 Parameter OUT_MODE, default 0: output mode. 0 = terminal pulse, 1 = toggle on wrap, 2 = duty compare.
REQ-004 Parameter DUTY, default 5: high-phase length in cycles for OUT_MODE 2.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset; rst=0 resets, rst=1 runs.
REQ-007 Port out, output, 1 bit: registered mode-dependent output.
REQ-008 The block SHALL contain an internal register named cnt, WIDTH bits wide, reachable by hierarchical reference for monitoring.

Function
REQ-009 There is no enable: with rst=1, cnt SHALL increment by 1 on every rising clk edge.
REQ-010 When cnt==MAX_COUNT, the next edge SHALL load cnt=0 (wrap); cnt SHALL never exceed MAX_COUNT.
REQ-011 Increment arithmetic SHALL be unsigned, WIDTH bits, with no carry-out port.
REQ-012 out SHALL be a flop whose next value derives from next-cnt, so out aligns to the same cycle as the cnt value it describes.
REQ-013 OUT_MODE 0: out SHALL be 1 exactly during cycles where cnt==MAX_COUNT, else 0; one-cycle pulse per period of MAX_COUNT+1 cycles.
REQ-014 OUT_MODE 1: out SHALL invert on each edge where cnt wraps MAX_COUNT->0, giving a 50% square wave of period 2*(MAX_COUNT+1) cycles.
REQ-015 OUT_MODE 2: out SHALL be 1 during cycles where cnt<DUTY, else 0.
REQ-016 OUT_MODE 2 with DUTY=0: out SHALL stay 0.
REQ-017 OUT_MODE 2 with DUTY=MAX_COUNT+1: out SHALL be 1 in every cycle after the first edge following reset release.
REQ-018 MAX_COUNT=0: cnt SHALL stay 0.
REQ-019 MAX_COUNT=0, mode 0: out SHALL be 1 every cycle after the first post-reset edge.
REQ-020 MAX_COUNT=0, mode 1: out SHALL toggle every edge.
REQ-021 Elaboration SHALL fail if any of the following hold: MAX_COUNT>2^WIDTH-1; DUTY>MAX_COUNT+1; OUT_MODE not in {0,1,2}; WIDTH<1.
REQ-022 Out-of-range cnt (unreachable in normal operation) SHALL load 0 on the next edge.

Reset
REQ-023 While rst=0, cnt SHALL be 0 and out SHALL be 0 immediately, without waiting for a clk edge, in all modes.
REQ-024 Reset SHALL dominate clk; edges during reset SHALL have no effect.
REQ-025 On the first rising edge after rst rises, cnt SHALL become 1.
REQ-026 On that same edge, out SHALL take its mode value for cnt=1.
REQ-027 Reset asserted mid-count SHALL clear cnt and out at once.
REQ-028 After reset is re-released mid-count, counting SHALL restart from 0 with no memory of the prior phase.
REQ-029 Mode 1 phase SHALL restart at out=0.

Verification
REQ-030 Defaults, clk period 10 ns, rst=0 for 15 ns then 1 for 100 ns.
- cnt sequence after release SHALL be 1,2,...,9,0 on successive edges.
- out SHALL be 1 only while cnt=9.
REQ-031 rst=0 asserted asynchronously mid-cycle while cnt=6 -> cnt=0 and out=0 before the next clk edge; after release, cnt=1 on the first edge.
REQ-032 OUT_MODE=1, MAX_COUNT=3 -> out=0 for 4 cycles, then 1 for 4 cycles, repeating, with transitions coincident with cnt 3->0.
REQ-033 OUT_MODE=2, MAX_COUNT=9, DUTY=3 -> out=1 while cnt in {0,1,2}, 0 for cnt 3..9; also check DUTY=0 (always 0) and DUTY=10 (always 1 after first edge).
REQ-034 WIDTH=3, MAX_COUNT=7 -> full binary wrap 111->000 with no illegal values; out pulses once per 8 cycles in mode 0.
REQ-035 Parameter-check elaboration cases SHALL each fail:
- MAX_COUNT=16 with WIDTH=4;
- DUTY=11 with MAX_COUNT=9;
- OUT_MODE=3.
